// File: rtl/banked_mem_responder.sv
`timescale 1ns/1ps
// Four-bank word memory responder: one request per cycle, per-bank busy window, pipelined reads.
// Latency: writes commit at the accept edge; read data valid RD_LAT cycles after the accept edge.
// Backpressure: a request to a busy bank raises stall and must be held until the bank frees.
module banked_mem_responder #(
  parameter int BANK_CYCLES = 4,
  parameter int RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        rd_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam logic [3:0] LP_LOAD = 4'(BANK_CYCLES);

  logic [1:0]  w_bank;
  logic [14:0] w_widx;
  logic        w_req;
  logic        w_err;
  logic        w_stall;
  logic        w_acc;
  logic        w_acc_wr;
  logic        w_acc_rd;

  logic [3:0]  r_cnt [4];
  logic [15:0] r_mem [32768];
  logic [15:0] r_pipe_dat [RD_LAT];
  logic        r_pipe_vld [RD_LAT];

  assign w_bank = addr[2:1];
  assign w_widx = addr[15:1];

  // Classify the current request: illegal, blocked by a busy bank, or accepted.
  // Requests are ignored while reset is held so no flag can fire during reset.
  always_comb begin
    w_req    = rst & (wr | rd);
    w_err    = (w_req & wr & rd) | (w_req & addr[0]);
    w_stall  = w_req & ~w_err & busy[w_bank];
    w_acc    = w_req & ~w_err & ~w_stall;
    w_acc_wr = w_acc & wr;
    w_acc_rd = w_acc & rd;
  end

  assign err   = w_err;
  assign stall = w_stall;

  // Per-bank busy counters: load on accept, otherwise count down to zero.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt[b] <= 4'd0;
      end else if (w_acc && (w_bank == 2'(b))) begin
        r_cnt[b] <= LP_LOAD;
      end else if (r_cnt[b] != 4'd0) begin
        r_cnt[b] <= r_cnt[b] - 4'd1;
      end
    end
    assign busy[b] = (r_cnt[b] != 4'd0);
  end

  // Storage array; deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      r_mem[w_widx] <= data_in;
    end
  end

  // Read pipeline: stage 0 captures the word on accept, later stages shift it out.
  // Non-valid stages carry zero so data_out is zero whenever rd_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_dat[i] <= 16'd0;
      end
    end else begin
      r_pipe_vld[0] <= w_acc_rd;
      r_pipe_dat[0] <= w_acc_rd ? r_mem[w_widx] : 16'd0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
      end
    end
  end

  assign data_out = r_pipe_dat[RD_LAT-1];
  assign rd_valid = r_pipe_vld[RD_LAT-1];

endmodule

// File: tb/tb_banked_mem_responder.sv
`timescale 1ns/1ps
// Bench for banked_mem_responder: two instances (default and BANK_CYCLES=1/RD_LAT=1)
// checked every cycle against a cycle-count based model, plus directed literal checks.
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_s [2];
  logic [15:0] din_s  [2];
  logic [15:0] dout_s [2];
  logic        wr_s   [2];
  logic        rd_s   [2];
  logic        vld_s  [2];
  logic        stall_s[2];
  logic        err_s  [2];
  logic [3:0]  busy_s [2];

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) n++;

  banked_mem_responder dut0 (
    .clk(clk), .rst(rst), .addr(addr_s[0]), .data_in(din_s[0]), .wr(wr_s[0]), .rd(rd_s[0]),
    .data_out(dout_s[0]), .rd_valid(vld_s[0]), .stall(stall_s[0]), .busy(busy_s[0]), .err(err_s[0])
  );

  banked_mem_responder #(.BANK_CYCLES(1), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr_s[1]), .data_in(din_s[1]), .wr(wr_s[1]), .rd(rd_s[1]),
    .data_out(dout_s[1]), .rd_valid(vld_s[1]), .stall(stall_s[1]), .busy(busy_s[1]), .err(err_s[1])
  );

  function automatic int bc(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int rl(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(string name, int inst, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A bank is busy while fewer than BANK_CYCLES edges have passed since its last accept;
  // a read accepted at edge e returns in the cycle following edge e+RD_LAT-1.
  typedef struct {
    int          due;
    logic [15:0] dat;
  } exp_t;

  exp_t        eq [2][$];
  logic [15:0] mem_m [2][32768];
  int          acc_edge [2][4];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) acc_edge[i][b] = -1000;
  end

  always @(negedge clk) begin : cmp
    logic [3:0]  eb;
    logic        ev;
    logic [15:0] ed;
    logic        ereq, eerr, estall;
    int          b;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        eq[i].delete();
        for (int k = 0; k < 4; k++) acc_edge[i][k] = -1000;
        chk("rst_busy", i, 16'(busy_s[i]), 16'h0000);
        chk("rst_valid", i, 16'(vld_s[i]), 16'h0000);
        chk("rst_data", i, dout_s[i], 16'h0000);
        chk("rst_stall", i, 16'(stall_s[i]), 16'h0000);
        chk("rst_err", i, 16'(err_s[i]), 16'h0000);
      end else begin
        for (int k = 0; k < 4; k++) eb[k] = (n - acc_edge[i][k]) < bc(i);
        ev = (eq[i].size() > 0) && (eq[i][0].due == n);
        ed = ev ? eq[i][0].dat : 16'h0000;
        if (ev) void'(eq[i].pop_front());
        chk("busy", i, 16'(busy_s[i]), 16'(eb));
        chk("rd_valid", i, 16'(vld_s[i]), 16'(ev));
        chk("data_out", i, dout_s[i], ed);
        ereq   = wr_s[i] | rd_s[i];
        eerr   = (wr_s[i] & rd_s[i]) | (ereq & addr_s[i][0]);
        b      = int'(addr_s[i][2:1]);
        estall = ereq & ~eerr & eb[b];
        chk("err", i, 16'(err_s[i]), 16'(eerr));
        chk("stall", i, 16'(stall_s[i]), 16'(estall));
        if (ereq && !eerr && !estall) begin
          acc_edge[i][b] = n + 1;
          if (wr_s[i]) begin
            mem_m[i][addr_s[i][15:1]] = din_s[i];
          end else begin
            e.due = n + rl(i);
            e.dat = mem_m[i][addr_s[i][15:1]];
            eq[i].push_back(e);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i, logic w, logic r, logic [15:0] a, logic [15:0] d);
    wr_s[i]   = w;
    rd_s[i]   = r;
    addr_s[i] = a;
    din_s[i]  = d;
  endtask

  // Present a request, hold it while stalled, return in the cycle after the accept edge.
  task automatic do_req(int i, logic w, logic r, logic [15:0] a, logic [15:0] d, output int stalls);
    stalls = 0;
    drive(i, w, r, a, d);
    #1;
    while (stall_s[i] && stalls < 40) begin
      stalls++;
      step();
    end
    if (stalls >= 40) begin
      checks++;
      failures++;
      $display("FAIL stall_timeout inst%0d t=%0t got=stalled want=accept", i, $time);
    end
    step();
    drive(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wait_idle(int i);
    repeat (bc(i) + 1) step();
  endtask

  task automatic rnd(int i);
    bit          written [64];
    bit          hold;
    int          op, w;
    logic [15:0] a, d;
    hold = 1'b0;
    for (int k = 0; k < 64; k++) written[k] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        op = int'($urandom_range(0, 9));
        w  = int'($urandom_range(0, 63));
        a  = 16'h0100 + 16'(w * 2);
        d  = 16'($urandom);
        if (op <= 2) begin
          drive(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end else if (op <= 5 || !written[w]) begin
          drive(i, 1'b1, 1'b0, a, d);
          written[w] = 1'b1;
        end else if (op <= 8) begin
          drive(i, 1'b0, 1'b1, a, 16'h0000);
        end else if ($urandom_range(0, 1) == 1) begin
          drive(i, 1'b1, 1'b1, a, d);
        end else begin
          drive(i, 1'b0, 1'b1, a | 16'h0001, 16'h0000);
        end
      end
      #1;
      hold = stall_s[i];
      step();
    end
    drive(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s, cnt;
    logic [15:0] stream_a [4];
    rst = 1'b0;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) step();
    rst = 1'b1;
    step();

    // Write then read back 0xBEEF at 0x0010 (bank 0) on the default instance.
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, s);
    chk("wr_busy_bank0", 0, 16'(busy_s[0]), 16'h0001);
    cnt = 0;
    while (busy_s[0][0] && cnt < 20) begin
      cnt++;
      step();
    end
    chk("busy_window_len", 0, 16'(cnt), 16'd4);
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'h0000, s);
    chk("rd_no_stall", 0, 16'(s), 16'd0);
    chk("rd_not_yet", 0, 16'(vld_s[0]), 16'h0000);
    step();
    chk("rd_valid_lat2", 0, 16'(vld_s[0]), 16'h0001);
    chk("rd_data_beef", 0, dout_s[0], 16'hBEEF);
    step();
    chk("rd_strobe_one", 0, 16'(vld_s[0]), 16'h0000);
    wait_idle(0);

    // Preload words for the stall and streaming tests.
    do_req(0, 1'b1, 1'b0, 16'h0000, 16'h1111, s);
    do_req(0, 1'b1, 1'b0, 16'h0008, 16'h2222, s);
    do_req(0, 1'b1, 1'b0, 16'h0002, 16'h3333, s);
    do_req(0, 1'b1, 1'b0, 16'h0004, 16'h4444, s);
    do_req(0, 1'b1, 1'b0, 16'h0006, 16'h5555, s);
    do_req(0, 1'b1, 1'b0, 16'h0020, 16'h7777, s);
    wait_idle(0);

    // Same-bank stall: second read to bank 0 waits out the busy window.
    do_req(0, 1'b0, 1'b1, 16'h0000, 16'h0000, s);
    do_req(0, 1'b0, 1'b1, 16'h0008, 16'h0000, s);
    chk("same_bank_stalls", 0, 16'(s), 16'd4);
    wait_idle(0);

    // Different-bank streaming on consecutive cycles.
    stream_a[0] = 16'h0000; stream_a[1] = 16'h0002;
    stream_a[2] = 16'h0004; stream_a[3] = 16'h0006;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, 1'b1, stream_a[k], 16'h0000);
      #1;
      chk("stream_no_stall", 0, 16'(stall_s[0]), 16'h0000);
      step();
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("stream_all_busy", 0, 16'(busy_s[0]), 16'h000F);
    wait_idle(0);
    wait_idle(0);

    // Illegal requests: both strobes, then odd address.
    drive(0, 1'b1, 1'b1, 16'h0020, 16'h5A5A);
    #1;
    chk("err_wr_rd", 0, 16'(err_s[0]), 16'h0001);
    chk("err_no_stall", 0, 16'(stall_s[0]), 16'h0000);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("err_no_busy", 0, 16'(busy_s[0]), 16'h0000);
    drive(0, 1'b0, 1'b1, 16'h0021, 16'h0000);
    #1;
    chk("err_odd_addr", 0, 16'(err_s[0]), 16'h0001);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("err_no_valid", 0, 16'(vld_s[0]), 16'h0000);
    do_req(0, 1'b0, 1'b1, 16'h0020, 16'h0000, s);
    step();
    chk("err_array_kept", 0, dout_s[0], 16'h7777);
    wait_idle(0);

    // Reset during an in-flight read.
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'h0000, s);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 0, 16'(busy_s[0]), 16'h0000);
    chk("rst_mid_valid", 0, 16'(vld_s[0]), 16'h0000);
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'h0000, s);
    step();
    chk("rst_kept_beef", 0, dout_s[0], 16'hBEEF);
    wait_idle(0);

    // Fast instance: BANK_CYCLES=1, RD_LAT=1.
    do_req(1, 1'b1, 1'b0, 16'h0040, 16'hA5A5, s);
    do_req(1, 1'b1, 1'b0, 16'h0048, 16'h5A5A, s);
    wait_idle(1);
    do_req(1, 1'b0, 1'b1, 16'h0040, 16'h0000, s);
    chk("fast_valid1", 1, 16'(vld_s[1]), 16'h0001);
    chk("fast_data1", 1, dout_s[1], 16'hA5A5);
    do_req(1, 1'b0, 1'b1, 16'h0048, 16'h0000, s);
    chk("fast_stalls", 1, 16'(s), 16'd1);
    chk("fast_valid2", 1, 16'(vld_s[1]), 16'h0001);
    chk("fast_data2", 1, dout_s[1], 16'h5A5A);
    wait_idle(1);

    // Randomised traffic on both instances concurrently.
    fork
      rnd(0);
      rnd(1);
    join
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
